// File: rtl/multiword_add_seq_if.sv
// Stream bundle for multiword_add_seq: operand input channel and result output channel.
// MULTIWORD_ADD_SUB_EN adds the per-packet in_sub select to the input channel.
interface multiword_add_seq_if #(
  parameter int N = 4
) ();
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_a;
  logic [N-1:0] in_b;
  logic         in_last;
`ifdef MULTIWORD_ADD_SUB_EN
  logic         in_sub;
`endif
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_sum;
  logic         out_cout;
  logic         out_last;
  logic         out_err;

  // The adder side: consumes operand beats and produces result beats.
  modport slave (
    input  in_valid, in_a, in_b, in_last,
`ifdef MULTIWORD_ADD_SUB_EN
    input  in_sub,
`endif
    output in_ready,
    output out_valid, out_sum, out_cout, out_last, out_err,
    input  out_ready
  );

  // The environment side: sources operands and sinks results.
  modport master (
    output in_valid, in_a, in_b, in_last,
`ifdef MULTIWORD_ADD_SUB_EN
    output in_sub,
`endif
    input  in_ready,
    input  out_valid, out_sum, out_cout, out_last, out_err,
    output out_ready
  );
endinterface

// File: rtl/multiword_add_seq.sv
// Sequential multi-word adder: adds LS-word-first N-bit word pairs, chaining the carry across beats.
// Optional subtract mode (A - B) when MULTIWORD_ADD_SUB_EN is defined.
module multiword_add_seq #(
  parameter int N     = 4,
  parameter int WORDS = 4
) (
  input logic             clk,
  input logic             rst,
  multiword_add_seq_if.slave bus
);

  localparam int            CW       = $clog2(WORDS);
  localparam logic [CW-1:0] LAST_CNT = CW'(WORDS - 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] ACCUM = 1'b1;

  logic [0:0]    state;
  logic          carry_reg;
  logic [CW-1:0] beat_cnt;

  logic          accept;
  logic          sub_eff;
  logic          cin;
  logic          overrun;
  logic          pkt_end;
  logic [N-1:0]  b_eff;
  logic [N:0]    sum_full;

  // Single output stage: a new beat may enter whenever the current one leaves (or none is held).
  assign bus.in_ready = !bus.out_valid || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;

`ifdef MULTIWORD_ADD_SUB_EN
  logic sub_reg;

  // The first beat uses the live select; later beats use the value latched with it.
  assign sub_eff = (state == IDLE) ? bus.in_sub : sub_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sub_reg <= 1'b0;
    end else if (accept && state == IDLE) begin
      sub_reg <= bus.in_sub;
    end
  end
`else
  assign sub_eff = 1'b0;
`endif

  // In subtract mode the first-beat carry-in of 1 completes the two's complement of B.
  assign cin      = (state == IDLE) ? sub_eff : carry_reg;
  assign b_eff    = sub_eff ? ~bus.in_b : bus.in_b;
  assign sum_full = {1'b0, bus.in_a} + {1'b0, b_eff} + {{N{1'b0}}, cin};

  // A packet that reaches WORDS beats without in_last is cut off and flagged.
  assign overrun = (beat_cnt == LAST_CNT) && !bus.in_last;
  assign pkt_end = bus.in_last || overrun;

  // NOTE: every register here uses non-blocking assignment so all state updates
  // see pre-edge values; blocking assignments would create order-dependent races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      carry_reg <= 1'b0;
      beat_cnt  <= '0;
    end else if (accept) begin
      if (pkt_end) begin
        state     <= IDLE;
        carry_reg <= 1'b0;
        beat_cnt  <= '0;
      end else begin
        state     <= ACCUM;
        carry_reg <= sum_full[N];
        beat_cnt  <= beat_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.out_sum   <= '0;
      bus.out_cout  <= 1'b0;
      bus.out_last  <= 1'b0;
      bus.out_err   <= 1'b0;
    end else if (accept) begin
      bus.out_valid <= 1'b1;
      bus.out_sum   <= sum_full[N-1:0];
      bus.out_cout  <= pkt_end ? sum_full[N] : 1'b0;
      bus.out_last  <= pkt_end;
      bus.out_err   <= overrun;
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end

endmodule
